yellowball_motion: RTL and testbench
====================================

Name: yellowball_motion

Overview:
- Upstream stage of the yellow-ball sprite renderer.
- Holds the ball's screen position and runs a throw/flight/landed state machine that advances once per video frame.
- For every pixel it produces the sprite-relative offsets DistX/DistY and an in-sprite flag; the renderer turns these into ROM address and colour.
- Runs in the vga_clk domain alongside the VGA controller.

Parameters:
- SIZE, 20, sprite width and height in pixels (square).
- STEP, 2, pixels moved per frame while in flight.
- FLIGHT_FRAMES, 30, maximum frames spent in flight.
- LAND_FRAMES, 60, frames the ball stays visible after landing.
- H_MAX, 640, visible width.
- V_MAX, 480, visible height.

Ports:
- vga_clk  in  1  pixel clock.
- Reset  in  1  synchronous, active-high reset.
- DrawX  in  10  current pixel column from the VGA controller.
- DrawY  in  10  current pixel row.
- vs  in  1  vertical sync, active low; its rising edge is the frame tick.
- throw  in  1  single-cycle request to launch the ball.
- start_x  in  10  launch X (top-left), sampled with throw.
- start_y  in  10  launch Y, sampled with throw.
- dir  in  2  launch direction: 0 up, 1 down, 2 left, 3 right; sampled with throw.
- busy  out  1  high in FLIGHT and LANDED.
- ball_on  out  1  current pixel lies inside the visible sprite box.
- DistX  out  20  DrawX minus ball X while ball_on, else 0.
- DistY  out  20  DrawY minus ball Y while ball_on, else 0.

Behaviour:
- Reset: state IDLE; ball X/Y 0; frame counter 0; busy, ball_on, DistX, DistY all 0; the vs delay register is set to 1 so no tick is generated on the first cycle after reset.
- Frame tick: `tick = vs & ~vs_d`, one vga_clk wide.
- IDLE:
  - ball hidden (ball_on 0).
  - On throw: latch start_x, start_y and dir; clear the frame counter; go to FLIGHT on the next cycle.
- FLIGHT, on each tick:
  - Move STEP pixels in the latched direction.
  - Clamp X to [0, H_MAX-SIZE] and Y to [0, V_MAX-SIZE].
  - If clamping occurred, or the frame counter reaches FLIGHT_FRAMES-1, go to LANDED and clear the counter.
  - Otherwise increment the counter.
- LANDED, on each tick:
  - Position frozen; increment the counter.
  - At LAND_FRAMES-1 go to IDLE.
- throw while busy is ignored (no relatch).
- throw and tick in the same cycle in IDLE: throw wins; the first move happens on the next tick.
- Arithmetic:
  - Position uses 11-bit signed intermediates so left/up moves clamp at 0 rather than wrapping.
  - Box test: `DrawX >= X && DrawX < X+SIZE && DrawY >= Y && DrawY < Y+SIZE`.
  - DistX/DistY are zero-extended to 20 bits.
- Latency: ball_on, DistX and DistY are registered one vga_clk after DrawX/DrawY.
- Position updates take effect only on tick (during vertical blank), so no tearing within a frame.
- Reset mid-flight returns to IDLE immediately and hides the ball.
- busy is registered and equals (state != IDLE).

Optional Feature:
- YELLOWBALL_BLINK_EN defined: in LANDED, ball_on (and therefore DistX/DistY) is forced to 0 whenever frame counter bit 3 is 1, giving a blink with an 8-frame phase.
- YELLOWBALL_BLINK_EN undefined: the ball is solid throughout LANDED.
- FLIGHT is unaffected in both cases.

Decomposition:
- Package yellowball_pkg holds:
  - state enum {IDLE, FLIGHT, LANDED};
  - dir enum {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT};
  - constants BALL_SIZE = 20, SCREEN_W = 640, SCREEN_H = 480.
- One sub-module, frame_tick, implements the vs rising-edge detector with the reset behaviour above.
- Box test and offset arithmetic stay in the top module.

Test Plan:
- Reset, then run a full frame with no throw -> ball_on 0 and DistX/DistY 0 on every pixel; busy 0.
- throw with start (100,200), dir 3, then 5 ticks -> X = 110, Y = 200; pixel (115,205) gives ball_on 1, DistX 5, DistY 5 one cycle later; pixel (130,205) gives ball_on 0.
- throw with start (3,50), dir 2 -> after the 2nd tick X = 0 (clamped), state LANDED; after LAND_FRAMES more ticks busy falls to 0.
- throw at (300,300), dir 1, no walls -> exactly FLIGHT_FRAMES ticks of motion to Y = 360, then LANDED; a second throw pulsed during LANDED is ignored.
- Reset asserted 3 ticks into flight -> next cycle busy 0, ball_on 0; the first cycle after Reset deasserts produces no tick even with vs held high.
- With YELLOWBALL_BLINK_EN, in LANDED at counter values 8–15 -> ball_on 0 over the box; at 0–7 and 16–23 -> ball_on 1.

Source files
------------

// File: rtl/yellowball_pkg.sv
// Shared types and screen constants for the yellow-ball sprite pipeline.
package yellowball_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLIGHT = 2'd1,
        LANDED = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam int BALL_SIZE = 20;
    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;

    // Pin a signed candidate coordinate into [0, hi].
    function automatic logic [9:0] clamp_axis(input logic signed [11:0] v, input int hi);
        if (int'(v) < 0)
            return 10'd0;
        if (int'(v) > hi)
            return 10'(hi);
        return v[9:0];
    endfunction

endpackage

// File: rtl/frame_tick.sv
// Rising-edge detector on active-low vsync; one vga_clk pulse per frame.
module frame_tick (
    input  logic vga_clk,
    input  logic Reset,
    input  logic vs,
    output logic tick
);

    logic vs_d_reg;

    // Preset high so a vs already high when Reset releases is not seen as an edge.
    always_ff @(posedge vga_clk) begin
        if (Reset)
            vs_d_reg <= 1'b1;
        else
            vs_d_reg <= vs;
    end

    assign tick = vs & ~vs_d_reg;

endmodule

// File: rtl/yellowball_motion.sv
// Yellow-ball position/flight FSM plus per-pixel sprite box test and offsets.
// Build option: define YELLOWBALL_BLINK_EN to blink the ball while landed.
module yellowball_motion
    import yellowball_pkg::*;
#(
    parameter int SIZE          = BALL_SIZE,
    parameter int STEP          = 2,
    parameter int FLIGHT_FRAMES = 30,
    parameter int LAND_FRAMES   = 60,
    parameter int H_MAX         = SCREEN_W,
    parameter int V_MAX         = SCREEN_H
) (
    input  logic        vga_clk,
    input  logic        Reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        vs,
    input  logic        throw,
    input  logic [9:0]  start_x,
    input  logic [9:0]  start_y,
    input  logic [1:0]  dir,
    output logic        busy,
    output logic        ball_on,
    output logic [19:0] DistX,
    output logic [19:0] DistY
);

    localparam int CNT_MAX = (LAND_FRAMES > FLIGHT_FRAMES) ? LAND_FRAMES : FLIGHT_FRAMES;
    localparam int CNT_W   = ($clog2(CNT_MAX) < 4) ? 4 : $clog2(CNT_MAX);

    logic             tick;
    state_t           state_reg, state_next;
    dir_t             dir_reg, dir_next;
    logic [9:0]       ball_x_reg, ball_x_next;
    logic [9:0]       ball_y_reg, ball_y_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             busy_reg;
    logic             ball_on_reg;
    logic [19:0]      dist_x_reg, dist_y_reg;

    frame_tick u_frame_tick (
        .vga_clk (vga_clk),
        .Reset   (Reset),
        .vs      (vs),
        .tick    (tick)
    );

    // One bit of headroom beyond 11 so off-screen launch points still clamp, not wrap.
    logic signed [11:0] move_x, move_y;
    logic [9:0]         clamp_x, clamp_y;
    logic               hit_wall;

    always_comb begin
        move_x = $signed({2'b00, ball_x_reg});
        move_y = $signed({2'b00, ball_y_reg});
        case (dir_reg)
            DIR_UP:    move_y = move_y - 12'(STEP);
            DIR_DOWN:  move_y = move_y + 12'(STEP);
            DIR_LEFT:  move_x = move_x - 12'(STEP);
            DIR_RIGHT: move_x = move_x + 12'(STEP);
            default:   ;
        endcase
        clamp_x  = clamp_axis(move_x, H_MAX - SIZE);
        clamp_y  = clamp_axis(move_y, V_MAX - SIZE);
        hit_wall = (move_x != $signed({2'b00, clamp_x})) ||
                   (move_y != $signed({2'b00, clamp_y}));
    end

    always_comb begin
        state_next  = state_reg;
        dir_next    = dir_reg;
        ball_x_next = ball_x_reg;
        ball_y_next = ball_y_reg;
        cnt_next    = cnt_reg;
        case (state_reg)
            IDLE: begin
                // A coincident tick is ignored here, so the first move is one frame later.
                if (throw) begin
                    ball_x_next = start_x;
                    ball_y_next = start_y;
                    dir_next    = dir_t'(dir);
                    cnt_next    = '0;
                    state_next  = FLIGHT;
                end
            end
            FLIGHT: begin
                if (tick) begin
                    ball_x_next = clamp_x;
                    ball_y_next = clamp_y;
                    if (hit_wall || cnt_reg == CNT_W'(FLIGHT_FRAMES - 1)) begin
                        cnt_next   = '0;
                        state_next = LANDED;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            LANDED: begin
                if (tick) begin
                    if (cnt_reg == CNT_W'(LAND_FRAMES - 1)) begin
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    logic        visible;
    logic        in_box;
    logic        on_next;
    logic [10:0] x_end, y_end;

    assign x_end = {1'b0, ball_x_reg} + 11'(SIZE);
    assign y_end = {1'b0, ball_y_reg} + 11'(SIZE);

    always_comb begin
        visible = (state_reg != IDLE);
`ifdef YELLOWBALL_BLINK_EN
        if (state_reg == LANDED && cnt_reg[3])
            visible = 1'b0;
`endif
        in_box  = (DrawX >= ball_x_reg) && ({1'b0, DrawX} < x_end) &&
                  (DrawY >= ball_y_reg) && ({1'b0, DrawY} < y_end);
        on_next = visible && in_box;
    end

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            state_reg   <= IDLE;
            dir_reg     <= DIR_UP;
            ball_x_reg  <= '0;
            ball_y_reg  <= '0;
            cnt_reg     <= '0;
            busy_reg    <= 1'b0;
            ball_on_reg <= 1'b0;
            dist_x_reg  <= '0;
            dist_y_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            dir_reg     <= dir_next;
            ball_x_reg  <= ball_x_next;
            ball_y_reg  <= ball_y_next;
            cnt_reg     <= cnt_next;
            busy_reg    <= (state_next != IDLE);
            ball_on_reg <= on_next;
            dist_x_reg  <= on_next ? {10'd0, DrawX - ball_x_reg} : 20'd0;
            dist_y_reg  <= on_next ? {10'd0, DrawY - ball_y_reg} : 20'd0;
        end
    end

    assign busy    = busy_reg;
    assign ball_on = ball_on_reg;
    assign DistX   = dist_x_reg;
    assign DistY   = dist_y_reg;

endmodule

// File: tb/tb_yellowball_motion.sv
// Directed bench for yellowball_motion with a frame-level behavioural model.
module tb_yellowball_motion;

    localparam int SIZE          = 20;
    localparam int STEP          = 2;
    localparam int FLIGHT_FRAMES = 30;
    localparam int LAND_FRAMES   = 60;
    localparam int XMAX          = 640 - SIZE;
    localparam int YMAX          = 480 - SIZE;
    localparam int DDX [4]       = '{0, 0, -1, 1};
    localparam int DDY [4]       = '{-1, 1, 0, 0};

    logic        vga_clk = 1'b0;
    logic        Reset   = 1'b1;
    logic [9:0]  DrawX   = '0;
    logic [9:0]  DrawY   = '0;
    logic        vs      = 1'b1;
    logic        throw   = 1'b0;
    logic [9:0]  start_x = '0;
    logic [9:0]  start_y = '0;
    logic [1:0]  dir     = '0;
    logic        busy;
    logic        ball_on;
    logic [19:0] DistX;
    logic [19:0] DistY;

    yellowball_motion dut (
        .vga_clk (vga_clk),
        .Reset   (Reset),
        .DrawX   (DrawX),
        .DrawY   (DrawY),
        .vs      (vs),
        .throw   (throw),
        .start_x (start_x),
        .start_y (start_y),
        .dir     (dir),
        .busy    (busy),
        .ball_on (ball_on),
        .DistX   (DistX),
        .DistY   (DistY)
    );

    always #5 vga_clk = ~vga_clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Model: mode 0 idle, 1 flying, 2 landed; m_cnt counts frames in the current mode.
    int m_mode = 0, m_x = 0, m_y = 0, m_cnt = 0, m_dir = 0;
    bit m_vs_prev = 1'b1;
    int e_busy = 0, e_on = 0, e_dx = 0, e_dy = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Predict the outputs registered at the coming edge, then advance the model.
    task automatic model_step();
        bit tk, vis;
        int px, py, nx, ny, cx, cy;
        if (Reset) begin
            m_mode = 0; m_x = 0; m_y = 0; m_cnt = 0; m_vs_prev = 1'b1;
            e_busy = 0; e_on = 0; e_dx = 0; e_dy = 0;
            return;
        end
        tk = vs && !m_vs_prev;
        m_vs_prev = vs;
        vis = (m_mode != 0);
`ifdef YELLOWBALL_BLINK_EN
        if (m_mode == 2 && ((m_cnt / 8) % 2) == 1)
            vis = 1'b0;
`endif
        px = int'(DrawX);
        py = int'(DrawY);
        if (vis && px >= m_x && px < m_x + SIZE && py >= m_y && py < m_y + SIZE) begin
            e_on = 1; e_dx = px - m_x; e_dy = py - m_y;
        end else begin
            e_on = 0; e_dx = 0; e_dy = 0;
        end
        if (m_mode == 0) begin
            if (throw) begin
                m_x = int'(start_x); m_y = int'(start_y); m_dir = int'(dir);
                m_cnt = 0; m_mode = 1;
            end
        end else if (tk) begin
            if (m_mode == 1) begin
                nx = m_x + DDX[m_dir] * STEP;
                ny = m_y + DDY[m_dir] * STEP;
                cx = (nx < 0) ? 0 : ((nx > XMAX) ? XMAX : nx);
                cy = (ny < 0) ? 0 : ((ny > YMAX) ? YMAX : ny);
                m_x = cx; m_y = cy; m_cnt++;
                if (cx != nx || cy != ny || m_cnt == FLIGHT_FRAMES) begin
                    m_mode = 2; m_cnt = 0;
                end
            end else begin
                m_cnt++;
                if (m_cnt == LAND_FRAMES) begin
                    m_mode = 0; m_cnt = 0;
                end
            end
        end
        e_busy = (m_mode != 0) ? 1 : 0;
    endtask

    always @(posedge vga_clk) begin
        #1;
        if (chk_en) begin
            chk("busy", int'(busy), e_busy);
            chk("ball_on", int'(ball_on), e_on);
            chk("DistX", int'(DistX), e_dx);
            chk("DistY", int'(DistY), e_dy);
        end
    end

    task automatic cycle(input int px, input int py, input bit v, input bit t);
        @(negedge vga_clk);
        DrawX = 10'(px);
        DrawY = 10'(py);
        vs    = v;
        throw = t;
        model_step();
        chk_en = 1'b1;
        @(posedge vga_clk);
        #2;
    endtask

    // Short frame: vsync low, rising edge, then probes around the box edges.
    task automatic frame();
        cycle(0, 0, 1'b0, 1'b0);
        cycle(0, 0, 1'b1, 1'b0);
        cycle(m_x - 1, m_y, 1'b1, 1'b0);
        cycle(m_x, m_y, 1'b1, 1'b0);
        cycle(m_x + SIZE - 1, m_y + SIZE - 1, 1'b1, 1'b0);
        cycle(m_x + SIZE, m_y + 5, 1'b1, 1'b0);
        cycle(m_x + 5, m_y + SIZE, 1'b1, 1'b0);
        cycle(m_x + 7, m_y - 1, 1'b1, 1'b0);
    endtask

    task automatic launch(input int sx, input int sy, input int d, input bit v);
        start_x = 10'(sx);
        start_y = 10'(sy);
        dir     = 2'(d);
        cycle(0, 0, v, 1'b1);
    endtask

    task automatic run_idle();
        int n = 0;
        while (busy && n < 200) begin
            frame();
            n++;
        end
        chk("idle_bound", int'(busy), 0);
    endtask

    initial begin
        Reset = 1'b1;
        repeat (3) cycle(0, 0, 1'b1, 1'b0);
        Reset = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_on", int'(ball_on), 0);
        chk("rst_distx", int'(DistX), 0);

        // Idle frame: nothing drawn anywhere.
        cycle(0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++)
            cycle(i * 16, i * 12, 1'b1, 1'b0);
        chk("idle_busy", int'(busy), 0);

        // Rightward throw from (100,200).
        launch(100, 200, 3, 1'b1);
        chk("t2_busy", int'(busy), 1);
        repeat (5) frame();
        chk("t2_model_x", m_x, 110);
        cycle(115, 205, 1'b1, 1'b0);
        chk("t2_on", int'(ball_on), 1);
        chk("t2_distx", int'(DistX), 5);
        chk("t2_disty", int'(DistY), 5);
        cycle(130, 205, 1'b1, 1'b0);
        chk("t2_edge_on", int'(ball_on), 0);
        chk("t2_edge_distx", int'(DistX), 0);
        run_idle();

        // Leftward throw from (3,50), launched on the same cycle as a tick.
        cycle(0, 0, 1'b0, 1'b0);
        launch(3, 50, 2, 1'b1);
        frame();
        chk("t3_model_x1", m_x, 1);
        cycle(1, 50, 1'b1, 1'b0);
        chk("t3_x1_on", int'(ball_on), 1);
        chk("t3_x1_distx", int'(DistX), 0);
        frame();
        chk("t3_model_x0", m_x, 0);
        chk("t3_model_landed", m_mode, 2);
        cycle(0, 50, 1'b1, 1'b0);
        chk("t3_wall_on", int'(ball_on), 1);
        chk("t3_wall_distx", int'(DistX), 0);
        repeat (LAND_FRAMES - 1) frame();
        chk("t3_still_busy", int'(busy), 1);
        frame();
        chk("t3_busy_done", int'(busy), 0);

        // Downward flight limited by frame count; a throw while landed is ignored.
        launch(300, 300, 1, 1'b1);
        repeat (FLIGHT_FRAMES - 1) frame();
        chk("t4_model_y29", m_y, 358);
        chk("t4_model_flying", m_mode, 1);
        frame();
        chk("t4_model_y30", m_y, 360);
        chk("t4_model_landed", m_mode, 2);
        cycle(319, 379, 1'b1, 1'b0);
        chk("t4_corner_distx", int'(DistX), 19);
        chk("t4_corner_disty", int'(DistY), 19);
        launch(10, 10, 0, 1'b1);
        frame();
        cycle(300, 360, 1'b1, 1'b0);
        chk("t4_ignored_on", int'(ball_on), 1);
        chk("t4_busy", int'(busy), 1);
        repeat (9) frame();
        chk("t4_model_cnt", m_cnt, 10);
        cycle(305, 365, 1'b1, 1'b0);
`ifdef YELLOWBALL_BLINK_EN
        chk("t4_blink_off", int'(ball_on), 0);
`else
        chk("t4_solid_on", int'(ball_on), 1);
`endif
        repeat (6) frame();
        cycle(305, 365, 1'b1, 1'b0);
        chk("t4_cnt16_on", int'(ball_on), 1);
        run_idle();

        // Reset three ticks into an upward flight.
        launch(200, 100, 0, 1'b1);
        repeat (3) frame();
        chk("t5_model_y", m_y, 94);
        Reset = 1'b1;
        cycle(205, 97, 1'b1, 1'b0);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_on", int'(ball_on), 0);
        Reset = 1'b0;
        cycle(205, 97, 1'b1, 1'b0);
        chk("t5_post_busy", int'(busy), 0);
        chk("t5_post_on", int'(ball_on), 0);

        // Rightward throw that reaches the right wall.
        launch(600, 400, 3, 1'b1);
        repeat (11) frame();
        chk("t6_model_x", m_x, 620);
        chk("t6_model_landed", m_mode, 2);
        run_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
